// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with a blocking 4-word line fill.
// Hits return data in the same cycle; misses stall the fetch stage until the refill completes.
module icache_fill #(
   parameter int unsigned NSETS = 16,
   parameter int unsigned WPL   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   input  logic        invalidate,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] instrF,
   output logic        icache_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr
);

   localparam int unsigned IDX_W = $clog2(NSETS);
   localparam int unsigned OFF_W = 2;
   localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WPL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [OFF_W-1:0]   cnt_q, cnt_d;
   logic [TAG_W-1:0]   ltag_q, ltag_d;
   logic [IDX_W-1:0]   lidx_q, lidx_d;
   logic [NSETS-1:0]   valid_q, valid_d;

   logic [31:0]        data_mem [NSETS][WPL];
   logic [TAG_W-1:0]   tag_mem  [NSETS];

   logic [OFF_W-1:0]   off_c;
   logic [IDX_W-1:0]   idx_c;
   logic [TAG_W-1:0]   tag_c;
   logic               hit_c;
   logic               data_we_c;
   logic               tag_we_c;
   logic               unused_pc_bits;

   // Byte offset within a word carries no information for instruction fetch.
   assign unused_pc_bits = ^pcF[1:0];

   assign off_c = pcF[2 +: OFF_W];
   assign idx_c = pcF[2 + OFF_W +: IDX_W];
   assign tag_c = pcF[2 + OFF_W + IDX_W +: TAG_W];

   assign hit_c = (state_q == IDLE) && valid_q[idx_c] && (tag_mem[idx_c] == tag_c);

   assign instrF       = hit_c ? data_mem[idx_c][off_c] : 32'h0000_0000;
   assign icache_stall = !hit_c;
   assign mem_req      = (state_q == FILL);
   assign mem_addr     = mem_req ? {ltag_q, lidx_q, cnt_q, 2'b00} : 32'h0000_0000;

   // Next-state and fill control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ltag_d    = ltag_q;
      lidx_d    = lidx_q;
      valid_d   = valid_q;
      data_we_c = 1'b0;
      tag_we_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (invalidate) begin
               valid_d = '0;
            end else if (!hit_c) begin
               state_d        = FILL;
               ltag_d         = tag_c;
               lidx_d         = idx_c;
               cnt_d          = '0;
               valid_d[idx_c] = 1'b0;
            end
         end
         FILL: begin
            if (mem_ready) begin
               data_we_c = 1'b1;
               cnt_d     = cnt_q + OFF_W'(1);
               if (cnt_q == LAST_WORD) begin
                  state_d         = DONE;
                  tag_we_c        = 1'b1;
                  valid_d[lidx_q] = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ltag_q  <= '0;
         lidx_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ltag_q  <= ltag_d;
         lidx_q  <= lidx_d;
         valid_q <= valid_d;
      end
   end

   // Line storage is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      if (data_we_c) begin
         data_mem[lidx_q][cnt_q] <= mem_rdata;
      end
      if (tag_we_c) begin
         tag_mem[lidx_q] <= ltag_q;
      end
   end

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: table of fetch accesses with an address scoreboard,
// plus hand sequences for invalidate and reset during a fill.
module tb_icache_fill;

   logic        clk;
   logic        rst;
   logic [31:0] pcF;
   logic        invalidate;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] instrF;
   logic        icache_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] salt;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] sb [$];

   typedef struct {
      logic [31:0] pc;
      bit          miss;
      int          period;
      bit          wiggle;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];

   icache_fill #(.NSETS(16), .WPL(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pcF          (pcF),
      .invalidate   (invalidate),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .instrF       (instrF),
      .icache_stall (icache_stall),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr)
   );

   // Backing memory returns a salted copy of the requested address.
   assign mem_rdata = mem_addr ^ salt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic access(input logic [31:0] pc, input bit miss, input int period,
                         input bit wiggle, input logic [31:0] exp, input string nm);
      int k;
      int exp_stall;
      logic [31:0] line;
      k = 0;
      line = {pc[31:4], 4'h0};
      exp_stall = miss ? (2 + 4 * period) : 0;
      sb.delete();
      if (miss) begin
         for (int w = 0; w < 4; w++) sb.push_back(line + 32'(w * 4));
      end
      forever begin
         @(negedge clk);
         invalidate = wiggle && (k >= 1) && (k <= 5);
         pcF        = (wiggle && (k >= 1) && (k <= 4)) ? (pc ^ 32'h0000_0300) : pc;
         mem_ready  = (period <= 1) || ((k % period) == 0);
         #2;
         if (k == 0) check({nm, " idle mem_req"}, 32'(mem_req), 32'd0);
         if (mem_req) begin
            if (sb.size() == 0) begin
               check({nm, " spurious mem_req"}, 32'(mem_req), 32'd0);
            end else begin
               check({nm, " mem_addr"}, mem_addr, sb[0]);
               if (mem_ready) void'(sb.pop_front());
            end
         end
         if (!icache_stall) break;
         k++;
         if (k > 100) break;
      end
      check({nm, " stall cycles"}, 32'(k), 32'(exp_stall));
      check({nm, " instrF"}, instrF, exp);
      check({nm, " words left"}, 32'(sb.size()), 32'd0);
      check({nm, " hit mem_req"}, 32'(mem_req), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0040, 1'b1, 1, 1'b0, 32'h0000_0040};
      vecs[1]  = '{32'h0000_0044, 1'b0, 1, 1'b0, 32'h0000_0044};
      vecs[2]  = '{32'h0000_0048, 1'b0, 1, 1'b0, 32'h0000_0048};
      vecs[3]  = '{32'h0000_004C, 1'b0, 1, 1'b0, 32'h0000_004C};
      vecs[4]  = '{32'h0000_0043, 1'b0, 1, 1'b0, 32'h0000_0040};
      vecs[5]  = '{32'h0000_0140, 1'b1, 1, 1'b0, 32'h0000_0140};
      vecs[6]  = '{32'h0000_014C, 1'b0, 1, 1'b0, 32'h0000_014C};
      vecs[7]  = '{32'h0000_0040, 1'b1, 1, 1'b0, 32'h0000_0040};
      vecs[8]  = '{32'h0000_0080, 1'b1, 3, 1'b0, 32'h0000_0080};
      vecs[9]  = '{32'h0000_0088, 1'b0, 1, 1'b0, 32'h0000_0088};
      vecs[10] = '{32'h0000_0048, 1'b0, 1, 1'b0, 32'h0000_0048};
      vecs[11] = '{32'h0000_00F0, 1'b1, 1, 1'b0, 32'h0000_00F0};
      vecs[12] = '{32'h0000_00FC, 1'b0, 1, 1'b0, 32'h0000_00FC};
      vecs[13] = '{32'hFFFF_FFF0, 1'b1, 2, 1'b0, 32'hFFFF_FFF0};
      vecs[14] = '{32'h0000_00F4, 1'b1, 1, 1'b0, 32'h0000_00F4};
      vecs[15] = '{32'h0000_01C8, 1'b1, 1, 1'b1, 32'h0000_01C8};
      vecs[16] = '{32'h0000_01C4, 1'b0, 1, 1'b0, 32'h0000_01C4};
      vecs[17] = '{32'h0000_0084, 1'b0, 1, 1'b0, 32'h0000_0084};

      rst        = 1'b1;
      pcF        = 32'h0000_0040;
      invalidate = 1'b0;
      mem_ready  = 1'b1;
      salt       = 32'h0000_0000;

      #12;
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset instrF", instrF, 32'd0);
      check("reset stall", 32'(icache_stall), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("post-reset mem_req", 32'(mem_req), 32'd0);
      check("post-reset stall", 32'(icache_stall), 32'd1);
      check("post-reset instrF", instrF, 32'd0);

      for (int i = 0; i < 18; i++) begin
         access(vecs[i].pc, vecs[i].miss, vecs[i].period, vecs[i].wiggle, vecs[i].exp,
                $sformatf("vec%0d", i));
      end

      // Invalidate in IDLE beats a simultaneous miss and empties every line.
      salt = 32'h5A00_0000;
      @(negedge clk);
      pcF        = 32'h0000_0200;
      invalidate = 1'b1;
      #2;
      check("inv stall", 32'(icache_stall), 32'd1);
      check("inv instrF", instrF, 32'd0);
      access(32'h0000_0040, 1'b1, 1, 1'b0, 32'h5A00_0040, "inv refill 40");
      access(32'h0000_0080, 1'b1, 1, 1'b0, 32'h5A00_0080, "inv refill 80");
      access(32'h0000_0044, 1'b0, 1, 1'b0, 32'h5A00_0044, "inv hit 44");

      // Reset arriving after two fill words aborts the fill.
      salt = 32'h00C0_0000;
      @(negedge clk);
      pcF        = 32'h0000_0040;
      invalidate = 1'b1;
      mem_ready  = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      #2;
      check("rstfill miss", 32'(icache_stall), 32'd1);
      @(negedge clk);
      #2;
      check("rstfill w0", mem_addr, 32'h0000_0040);
      @(negedge clk);
      #2;
      check("rstfill w1", mem_addr, 32'h0000_0044);
      @(negedge clk);
      #2;
      check("rstfill w2", mem_addr, 32'h0000_0048);
      rst = 1'b1;
      #1;
      check("rstfill mem_req", 32'(mem_req), 32'd0);
      check("rstfill mem_addr", mem_addr, 32'd0);
      check("rstfill stall", 32'(icache_stall), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      access(32'h0000_0040, 1'b1, 1, 1'b0, 32'h00C0_0040, "rst refill 40");
      access(32'h0000_004C, 1'b0, 1, 1'b0, 32'h00C0_004C, "rst hit 4c");
      access(32'h0000_0080, 1'b1, 1, 1'b0, 32'h00C0_0080, "rst refill 80");

      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
